// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//
// Central stall/flush sequencer for the five-stage pipeline. Stall requests
// from IF, ID, EX and MEM are resolved into a per-stage stall vector (the
// deepest requester wins). Exceptions and ERETs reported by the MEM stage are
// turned into a one-cycle flush plus PC redirect. The flush is deferred while
// the MEM stage is still waiting on the data bus.
//
// Optional feature (macro PIPE_CTRL_PERF_EN): stall-cycle and flush counters
// with a synchronous clear input.
//
// Ports:
//   clk_i            in   1   pipeline clock
//   rst_i            in   1   synchronous active-high reset
//   if_stall_req_i   in   1   instruction fetch not complete
//   id_stall_req_i   in   1   ID operand hazard on branch/jr
//   ex_stall_req_i   in   1   EX multi-cycle operation not done
//   mem_stall_req_i  in   1   data bus access not complete
//   excp_valid_i     in   1   MEM-stage exception or ERET
//   excp_eret_i      in   1   qualifies excp_valid_i as ERET
//   epc_i            in  32   return address for ERET
//   perf_clr_i       in   1   clear perf counters (PIPE_CTRL_PERF_EN only)
//   stall_cycles_o   out 32   cycles with stall_o != 0 (PIPE_CTRL_PERF_EN only)
//   flush_count_o    out 16   cycles with flush_o = 1 (PIPE_CTRL_PERF_EN only)
//   stall_o          out  6   bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM,
//                             bit4 MEM/WB, bit5 WB
//   flush_o          out  1   clear all pipeline registers, load PC
//   new_pc_o         out 32   redirect target, meaningful while flush_o = 1
//   dbg_state_o      out  2   current FSM state (0 RUN, 1 WAIT, 2 FLUSH)
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter logic [31:0] EXC_ENTRY = 32'hBFC00380
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_stall_req_i,
  input  logic        id_stall_req_i,
  input  logic        ex_stall_req_i,
  input  logic        mem_stall_req_i,
  input  logic        excp_valid_i,
  input  logic        excp_eret_i,
  input  logic [31:0] epc_i,
`ifdef PIPE_CTRL_PERF_EN
  input  logic        perf_clr_i,
  output logic [31:0] stall_cycles_o,
  output logic [15:0] flush_count_o,
`endif
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  state_e      state_q, state_d;
  logic [31:0] target_q, target_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic [5:0]  req_stall;
  logic [31:0] excp_target;

  // Deepest requester wins: stalling a stage also freezes every stage upstream.
  always_comb begin
    req_stall = STALL_NONE;
    if (mem_stall_req_i) begin
      req_stall = STALL_MEM;
    end else if (ex_stall_req_i) begin
      req_stall = STALL_EX;
    end else if (id_stall_req_i) begin
      req_stall = STALL_ID;
    end else if (if_stall_req_i) begin
      req_stall = STALL_IF;
    end
  end

  assign excp_target = excp_eret_i ? epc_i : EXC_ENTRY;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_RUN;
      target_q <= 32'h0;
      new_pc_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      new_pc_q <= new_pc_d;
    end
  end

  // new_pc is loaded on the edge that enters FLUSH, so it is valid exactly
  // when flush_o rises and simply holds afterwards.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    new_pc_d = new_pc_q;
    stall_o  = STALL_NONE;
    case (state_q)
      ST_RUN: begin
        stall_o = req_stall;
        if (excp_valid_i) begin
          target_d = excp_target;
          if (mem_stall_req_i) begin
            state_d = ST_WAIT;
          end else begin
            state_d  = ST_FLUSH;
            new_pc_d = excp_target;
          end
        end
      end
      ST_WAIT: begin
        // Freeze everything up to MEM/WB while the faulting access drains;
        // further exception reports are ignored until the flush is done.
        stall_o = STALL_MEM;
        if (!mem_stall_req_i) begin
          state_d  = ST_FLUSH;
          new_pc_d = target_q;
        end
      end
      ST_FLUSH: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign flush_o     = (state_q == ST_FLUSH);
  assign new_pc_o    = new_pc_q;
  assign dbg_state_o = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [15:0] flush_count_q;

  // Clear wins over increment; both counters wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i || perf_clr_i) begin
      stall_cycles_q <= 32'h0;
      flush_count_q  <= 16'h0;
    end else begin
      if (stall_o != STALL_NONE) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (flush_o) begin
        flush_count_q <= flush_count_q + 16'd1;
      end
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign flush_count_o  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  localparam logic [31:0] EXC = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifr, idr, exr, memr, ev, er;
  logic [31:0] epc;
  logic        perf_clr;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [1:0]  dbg_state;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.EXC_ENTRY(EXC)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .if_stall_req_i  (ifr),
    .id_stall_req_i  (idr),
    .ex_stall_req_i  (exr),
    .mem_stall_req_i (memr),
    .excp_valid_i    (ev),
    .excp_eret_i     (er),
    .epc_i           (epc),
`ifdef PIPE_CTRL_PERF_EN
    .perf_clr_i      (perf_clr),
    .stall_cycles_o  (stall_cycles),
    .flush_count_o   (flush_count),
`endif
    .stall_o         (stall),
    .flush_o         (flush),
    .new_pc_o        (new_pc),
    .dbg_state_o     (dbg_state)
  );

  // ---------------- reference model ----------------
  // Tracks "a redirect is owed but the bus is busy" and "the flush is
  // happening this cycle" as plain flags; stall vector is a thermometer code.
  logic        m_pending = 1'b0;
  logic        m_flush   = 1'b0;
  logic [31:0] m_tgt     = 32'h0;
  logic [31:0] m_pc      = 32'h0;
  logic [31:0] m_scnt    = 32'h0;
  logic [15:0] m_fcnt    = 16'h0;

  function automatic logic [5:0] prio(input logic i_r, d_r, e_r, m_r);
    int depth;
    depth = -1;
    if (i_r) depth = 1;
    if (d_r) depth = 2;
    if (e_r) depth = 3;
    if (m_r) depth = 4;
    if (depth < 0) return 6'd0;
    return 6'((1 << (depth + 1)) - 1);
  endfunction

  function automatic logic [5:0] model_stall();
    if (m_flush) return 6'd0;
    if (m_pending) return 6'h1f;
    return prio(ifr, idr, exr, memr);
  endfunction

  task automatic model_edge();
    logic [5:0] s;
    s = model_stall();
    if (rst) begin
      m_pending = 1'b0; m_flush = 1'b0; m_tgt = 32'h0; m_pc = 32'h0;
      m_scnt = 32'h0; m_fcnt = 16'h0;
    end else begin
      if (perf_clr) begin
        m_scnt = 32'h0; m_fcnt = 16'h0;
      end else begin
        m_scnt = m_scnt + ((s != 6'd0) ? 32'd1 : 32'd0);
        m_fcnt = m_fcnt + (m_flush ? 16'd1 : 16'd0);
      end
      if (m_flush) begin
        m_flush = 1'b0;
      end else if (m_pending) begin
        if (!memr) begin
          m_pending = 1'b0; m_flush = 1'b1; m_pc = m_tgt;
        end
      end else if (ev) begin
        m_tgt = er ? epc : EXC;
        if (memr) m_pending = 1'b1;
        else begin
          m_flush = 1'b1; m_pc = m_tgt;
        end
      end
    end
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst, ifr, idr, exr, memr, ev, er;
    logic [31:0] epc;
    logic [5:0]  stall;
    logic        fl;
    logic [31:0] pc;
  } vec_t;

  function automatic vec_t mk(input logic r, i_r, d_r, e_r, m_r, v, e, input logic [31:0] p,
                              input logic [5:0] s, input logic f, input logic [31:0] pc);
    vec_t t;
    t.rst = r; t.ifr = i_r; t.idr = d_r; t.exr = e_r; t.memr = m_r; t.ev = v; t.er = e;
    t.epc = p; t.stall = s; t.fl = f; t.pc = pc;
    return t;
  endfunction

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle(input bit use_tab, input vec_t v);
    @(negedge clk);
    check("stall_vs_model", {26'd0, stall}, {26'd0, model_stall()});
    check("flush_vs_model", {31'd0, flush}, {31'd0, m_flush});
    check("new_pc_vs_model", new_pc, m_pc);
`ifdef PIPE_CTRL_PERF_EN
    check("stall_cycles_vs_model", stall_cycles, m_scnt);
    check("flush_count_vs_model", {16'd0, flush_count}, {16'd0, m_fcnt});
`endif
    if (use_tab) begin
      check("stall_vs_table", {26'd0, stall}, {26'd0, v.stall});
      check("flush_vs_table", {31'd0, flush}, {31'd0, v.fl});
      check("new_pc_vs_table", new_pc, v.pc);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; ifr = v.ifr; idr = v.idr; exr = v.exr; memr = v.memr;
    ev = v.ev; er = v.er; epc = v.epc;
  endtask

  vec_t vecs[31];
  vec_t idle;

  initial begin
    //           rst if id ex mem ev er epc            stall  fl pc
    vecs[0]  = mk(0, 0, 1, 0, 1, 0, 0, 32'h0,        6'h1f, 0, 32'h0);
    vecs[1]  = mk(0, 0, 1, 0, 0, 0, 0, 32'h0,        6'h07, 0, 32'h0);
    vecs[2]  = mk(0, 1, 0, 0, 0, 0, 0, 32'h0,        6'h03, 0, 32'h0);
    vecs[3]  = mk(0, 0, 0, 1, 0, 0, 0, 32'h0,        6'h0f, 0, 32'h0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        6'h00, 0, 32'h0);
    // exception without bus stall
    vecs[5]  = mk(0, 0, 0, 0, 0, 1, 0, 32'h0,        6'h00, 0, 32'h0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        6'h00, 1, EXC);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        6'h00, 0, EXC);
    // ERET deferred by a 3-cycle bus stall
    vecs[8]  = mk(0, 0, 0, 0, 1, 1, 1, 32'h80001234, 6'h1f, 0, EXC);
    vecs[9]  = mk(0, 0, 0, 0, 1, 0, 0, 32'h0,        6'h1f, 0, EXC);
    vecs[10] = mk(0, 0, 0, 0, 1, 0, 0, 32'h0,        6'h1f, 0, EXC);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        6'h1f, 0, EXC);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        6'h00, 1, 32'h80001234);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        6'h00, 0, 32'h80001234);
    // excp_valid held across FLUSH
    vecs[14] = mk(0, 0, 0, 0, 0, 1, 0, 32'h0,        6'h00, 0, 32'h80001234);
    vecs[15] = mk(0, 0, 0, 0, 0, 1, 0, 32'h0,        6'h00, 1, EXC);
    vecs[16] = mk(0, 0, 0, 0, 0, 1, 0, 32'h0,        6'h00, 0, EXC);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        6'h00, 1, EXC);
    vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        6'h00, 0, EXC);
    // exception with concurrent stall; requests ignored in FLUSH, live again in RUN
    vecs[19] = mk(0, 0, 0, 1, 0, 1, 0, 32'h0,        6'h0f, 0, EXC);
    vecs[20] = mk(0, 0, 0, 1, 1, 0, 0, 32'h0,        6'h00, 1, EXC);
    vecs[21] = mk(0, 0, 0, 0, 1, 0, 0, 32'h0,        6'h1f, 0, EXC);
    vecs[22] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        6'h00, 0, EXC);
    // reset while waiting for the bus
    vecs[23] = mk(0, 0, 0, 0, 1, 1, 1, 32'h12345678, 6'h1f, 0, EXC);
    vecs[24] = mk(0, 0, 0, 0, 1, 0, 0, 32'h0,        6'h1f, 0, EXC);
    vecs[25] = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,        6'h1f, 0, EXC);
    vecs[26] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        6'h00, 0, 32'h0);
    vecs[27] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        6'h00, 0, 32'h0);
    // reset during the flush cycle
    vecs[28] = mk(0, 0, 0, 0, 0, 1, 0, 32'h0,        6'h00, 0, 32'h0);
    vecs[29] = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,        6'h00, 1, EXC);
    vecs[30] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        6'h00, 0, 32'h0);
    idle = mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 6'h00, 0, 32'h0);

    // clock/reset
    perf_clr = 1'b0;
    drive(idle);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cycle(1'b1, mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 6'h00, 0, 32'h0));

    // directed table
    for (int i = 0; i < 31; i++) begin
      drive(vecs[i]);
      cycle(1'b1, vecs[i]);
    end

`ifdef PIPE_CTRL_PERF_EN
    // counters: 4 stall cycles and one flush, then clear
    drive(idle);
    perf_clr = 1'b1;
    cycle(1'b0, idle);
    perf_clr = 1'b0;
    exr = 1'b1;
    repeat (4) cycle(1'b0, idle);
    exr = 1'b0; ev = 1'b1;
    cycle(1'b0, idle);
    ev = 1'b0;
    cycle(1'b0, idle);
    check("perf_stall_cycles", stall_cycles, 32'd4);
    check("perf_flush_count", {16'd0, flush_count}, 32'd1);
    perf_clr = 1'b1;
    cycle(1'b0, idle);
    perf_clr = 1'b0;
    check("perf_stall_cleared", stall_cycles, 32'd0);
    check("perf_flush_cleared", {16'd0, flush_count}, 32'd0);
`endif

    // randomized stimulus against the model
    for (int n = 0; n < 3000; n++) begin
      rst  = ($urandom_range(0, 79) == 0);
      ifr  = ($urandom_range(0, 3) == 0);
      idr  = ($urandom_range(0, 4) == 0);
      exr  = ($urandom_range(0, 5) == 0);
      memr = ($urandom_range(0, 2) == 0);
      ev   = ($urandom_range(0, 4) == 0);
      er   = $urandom_range(0, 1) == 1;
      epc  = $urandom;
`ifdef PIPE_CTRL_PERF_EN
      perf_clr = ($urandom_range(0, 49) == 0);
`endif
      cycle(1'b0, idle);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
